// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11 device-clocked bits, ACK check.
// Define PS2_TX_ACK_CHECK_EN to turn a missing device ACK into an error pulse.
module ps2_host_tx #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_US = 15000
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam logic [19:0] INH_CYC = 20'(CLK_HZ / 1_000_000 * INHIBIT_US);
    localparam logic [19:0] TO_CYC  = 20'(CLK_HZ / 1_000_000 * TIMEOUT_US);

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, DATA, ACK, WAIT_IDLE} state_t;

    state_t      state, state_n;
    logic [9:0]  shift, shift_n;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [19:0] timer, timer_n;
    logic        clk_oe_q, clk_oe_n, data_oe_q, data_oe_n;
    logic        done_q, done_n, error_q, error_n;
    logic        clk_meta, clk_sync, clk_prev, data_meta, data_sync;
    logic        fall;

    // Pins idle high, so the synchronisers reset to 1 to avoid a false fall.
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
        end
    end

    assign fall = clk_prev & ~clk_sync;

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift     <= '1;
            bit_cnt   <= '0;
            timer     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state     <= state_n;
            shift     <= shift_n;
            bit_cnt   <= bit_cnt_n;
            timer     <= timer_n;
            clk_oe_q  <= clk_oe_n;
            data_oe_q <= data_oe_n;
            done_q    <= done_n;
            error_q   <= error_n;
        end
    end

    always_comb begin
        state_n   = state;
        shift_n   = shift;
        bit_cnt_n = bit_cnt;
        timer_n   = timer;
        clk_oe_n  = clk_oe_q;
        data_oe_n = data_oe_q;
        done_n    = 1'b0;
        error_n   = 1'b0;

        case (state)
            IDLE: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                if (tx_valid) begin
                    shift_n   = {1'b1, ~^tx_data, tx_data};
                    bit_cnt_n = '0;
                    timer_n   = '0;
                    clk_oe_n  = 1'b1;
                    state_n   = INHIBIT;
                end
            end
            INHIBIT: begin
                timer_n = timer + 20'd1;
                // Start bit goes low one cycle before the clock is released.
                if (timer == INH_CYC - 20'd2) data_oe_n = 1'b1;
                if (timer == INH_CYC - 20'd1) begin
                    clk_oe_n  = 1'b0;
                    data_oe_n = 1'b1;
                    timer_n   = '0;
                    state_n   = RTS;
                end
            end
            RTS, DATA: begin
                if (fall) begin
                    data_oe_n = ~shift[0];
                    shift_n   = {1'b1, shift[9:1]};
                    bit_cnt_n = bit_cnt + 4'd1;
                    state_n   = (bit_cnt == 4'd9) ? ACK : DATA;
                end
            end
            ACK: begin
                if (fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
                    if (data_sync) begin
                        clk_oe_n  = 1'b0;
                        data_oe_n = 1'b0;
                        error_n   = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        state_n = WAIT_IDLE;
                    end
`else
                    state_n = WAIT_IDLE;
`endif
                end
            end
            WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Device-paced states share one inter-edge watchdog; it overrides everything.
        if (state == RTS || state == DATA || state == ACK || state == WAIT_IDLE) begin
            if (fall) begin
                timer_n = '0;
            end else if (timer == TO_CYC - 20'd1) begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                done_n    = 1'b0;
                error_n   = 1'b1;
                state_n   = IDLE;
            end else begin
                timer_n = timer + 20'd1;
            end
        end
    end

    assign tx_ready    = (state == IDLE);
    assign busy        = (state != IDLE);
    assign done        = done_q;
    assign error       = error_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule
